// File: rtl/addsub_seq_pkg.sv
// Shared types and constants for the digit-serial add/subtract sequencer.
package addsub_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } seq_state_e;

    localparam int unsigned DIGIT_W = 2;

    // Digit counter width; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/addsub_seq_ctrl.sv
// Drives an external 2-bit adder/subtractor slice one digit per clock, LSB first,
// chaining the carry and publishing result, carry out and signed overflow.
module addsub_seq_ctrl
    import addsub_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic [1:0]       slice_a_o,
    output logic [1:0]       slice_b_o,
    output logic             slice_cin_o,
    input  logic [1:0]       slice_sum_i,
    input  logic             slice_cout_i
);

    localparam int unsigned NDIG = WIDTH / DIGIT_W;
    localparam int unsigned IdxW = idx_width(NDIG);

    seq_state_e state_q, state_d;

    logic [WIDTH-1:0]         a_sh_q, a_sh_d;
    logic [WIDTH-1:0]         b_sh_q, b_sh_d;
    // Holds the digits already produced; the current slice_sum is prepended on top.
    logic [WIDTH-DIGIT_W-1:0] acc_q, acc_d;
    logic                     carry_q, carry_d;
    logic [IdxW-1:0]          idx_q, idx_d;
    logic                     a_msb_q, a_msb_d;
    logic                     b_msb_q, b_msb_d;
    logic [WIDTH-1:0]         result_q, result_d;
    logic                     cout_q, cout_d;
    logic                     ovf_q, ovf_d;

    logic [WIDTH-1:0]         b_eff;
    logic [WIDTH-1:0]         acc_full;

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        a_msb_d     = a_msb_q;
        b_msb_d     = b_msb_q;
        result_d    = result_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        slice_a_o   = '0;
        slice_b_o   = '0;
        slice_cin_o = 1'b0;
        b_eff       = sub_i ? ~op_b_i : op_b_i;
        acc_full    = {slice_sum_i, acc_q};

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    a_sh_d  = op_a_i;
                    b_sh_d  = b_eff;
                    carry_d = sub_i;
                    idx_d   = '0;
                    acc_d   = '0;
                    a_msb_d = op_a_i[WIDTH-1];
                    b_msb_d = b_eff[WIDTH-1];
                    state_d = StRun;
                end
            end
            StRun: begin
                slice_a_o   = a_sh_q[1:0];
                slice_b_o   = b_sh_q[1:0];
                slice_cin_o = carry_q;
                a_sh_d      = a_sh_q >> DIGIT_W;
                b_sh_d      = b_sh_q >> DIGIT_W;
                acc_d       = acc_full[WIDTH-1:DIGIT_W];
                carry_d     = slice_cout_i;
                idx_d       = idx_q + IdxW'(1);
                if (idx_q == IdxW'(NDIG - 1)) begin
                    result_d = acc_full;
                    cout_d   = slice_cout_i;
                    ovf_d    = (a_msb_q == b_msb_q) && (slice_sum_i[1] != a_msb_q);
                    state_d  = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy_o   = (state_q == StRun);
    assign done_o   = (state_q == StDone);
    assign result_o = result_q;
    assign cout_o   = cout_q;
    assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Self-checking bench: directed and random ops against an arithmetic reference model,
// with a behavioural 2-bit adder slice attached to the slice ports.
module tb_addsub_seq_ctrl;

    localparam int unsigned W    = 8;
    localparam int unsigned NDIG = W / 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         sub;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic [1:0]   slice_a;
    logic [1:0]   slice_b;
    logic         slice_cin;
    logic [1:0]   slice_sum;
    logic         slice_cout;
    logic [2:0]   slice_tot;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    assign slice_tot  = {1'b0, slice_a} + {1'b0, slice_b} + {2'b00, slice_cin};
    assign slice_sum  = slice_tot[1:0];
    assign slice_cout = slice_tot[2];

    addsub_seq_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start),
        .sub_i       (sub),
        .op_a_i      (op_a),
        .op_b_i      (op_b),
        .busy_o      (busy),
        .done_o      (done),
        .result_o    (result),
        .cout_o      (cout),
        .ovf_o       (ovf),
        .slice_a_o   (slice_a),
        .slice_b_o   (slice_b),
        .slice_cin_o (slice_cin),
        .slice_sum_i (slice_sum),
        .slice_cout_i(slice_cout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic ref_model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                             output logic [W-1:0] r, output logic c, output logic o);
        longint ua, ub, sa, sb, ur, sr, smax, smin;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -(longint'(1) << (W - 1));
        if (s) begin
            ur = ua - ub;
            c  = (ua >= ub);
            sr = sa - sb;
        end else begin
            ur = ua + ub;
            c  = (ur >= (longint'(1) << W));
            sr = sa + sb;
        end
        r = W'(ur);
        o = (sr > smax) || (sr < smin);
    endtask

    task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] er, b_eff, ta, tb;
        logic         ec, eo;
        int           lat, nbusy;
        ref_model(s, a, b, er, ec, eo);
        b_eff = s ? ~b : b;
        @(negedge clk);
        start = 1'b1;
        sub   = s;
        op_a  = a;
        op_b  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        nbusy = 0;
        for (int c = 0; c < int'(NDIG) + 4 && lat == 0; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (busy) begin
                ta = a >> (2 * nbusy);
                tb = b_eff >> (2 * nbusy);
                check("slice_a digit", 32'(slice_a), 32'(ta[1:0]));
                check("slice_b digit", 32'(slice_b), 32'(tb[1:0]));
                nbusy++;
            end
            if (done) lat = c;
        end
        check("done latency", 32'(lat), 32'(NDIG));
        check("busy cycles", 32'(nbusy), 32'(NDIG));
        check("result", 32'(result), 32'(er));
        check("cout", 32'(cout), 32'(ec));
        check("ovf", 32'(ovf), 32'(eo));
        check("slice idle in done", 32'({slice_a, slice_b, slice_cin}), 32'(0));
        @(posedge clk);
        #1;
        check("done one cycle", 32'(done), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int ndone, last_done;
        reset = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'(0));
        check("reset done", 32'(done), 32'(0));
        check("reset result", 32'(result), 32'(0));
        check("reset cout/ovf", 32'({cout, ovf}), 32'(0));
        check("reset slice", 32'({slice_a, slice_b, slice_cin}), 32'(0));
        @(negedge clk);
        reset = 1'b0;

        // Directed corner cases.
        run_op(1'b0, 8'h35, 8'h4A);
        run_op(1'b0, 8'h7F, 8'h01);
        run_op(1'b0, 8'hFF, 8'h01);
        run_op(1'b1, 8'h10, 8'h01);
        run_op(1'b1, 8'h00, 8'h01);
        run_op(1'b1, 8'h80, 8'h01);

        // start pulsed mid-run must be ignored.
        @(negedge clk);
        start = 1'b1; sub = 1'b0; op_a = 8'h35; op_b = 8'h4A;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b1; op_a = 8'h01; op_b = 8'h01;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("ignored start: dones", 32'(ndone), 32'(1));
        check("ignored start: result", 32'(result), 32'(8'h7F));

        // Reset in the middle of a run aborts it.
        @(negedge clk);
        start = 1'b1; sub = 1'b0; op_a = 8'h11; op_b = 8'h22;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort busy", 32'(busy), 32'(0));
        check("abort done", 32'(done), 32'(0));
        check("abort result", 32'(result), 32'(0));
        check("abort cout/ovf", 32'({cout, ovf}), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("abort no done", 32'(ndone), 32'(0));
        run_op(1'b0, 8'h35, 8'h4A);

        // start held high re-triggers every NDIG+2 cycles.
        @(negedge clk);
        start = 1'b1; sub = 1'b0; op_a = 8'h02; op_b = 8'h03;
        ndone     = 0;
        last_done = -1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                check("hold result", 32'(result), 32'(8'h05));
                if (last_done >= 0) check("hold period", 32'(c - last_done), 32'(NDIG + 2));
                last_done = c;
                ndone++;
            end
            if (!busy) check("hold slice idle", 32'({slice_a, slice_b, slice_cin}), 32'(0));
        end
        start = 1'b0;
        check("hold dones", 32'(ndone), 32'(5));
        repeat (3) @(posedge clk);

        // Random ops.
        for (int i = 0; i < 60; i++) begin
            run_op(1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
